// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: turns a resolved taken branch/jump into
// pipeline flushes, a valid/ready redirect to fetch, and a wrong-path
// squash window. Also flags misaligned targets and keeps branch statistics.
module branch_redirect_ctrl #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    input  logic             ex_is_bj_i,
    input  logic             stall_i,
    input  logic             pc_sel_i,
    input  logic [31:0]      ex_target_i,
    input  logic             fetch_ready_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             misalign_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bj_count_o,
    output logic [CNT_W-1:0] taken_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        SETTLE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] settle_q, settle_d;
    logic       resolve;
    logic       target_ok;
    logic       take;
    logic       take_misaligned;

    // Resolves only count while IDLE; anything in EX during a redirect is wrong-path.
    assign resolve         = ex_valid_i & ex_is_bj_i & ~stall_i & (state_q == IDLE);
    assign target_ok       = (ex_target_i[1:0] == 2'b00);
    assign take            = resolve & pc_sel_i & target_ok;
    assign take_misaligned = resolve & pc_sel_i & ~target_ok;

    // State and settle-counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic and flush/handshake outputs.
    always_comb begin
        state_d          = state_q;
        settle_d         = settle_q;
        redirect_valid_o = 1'b0;
        flush_if_id_o    = 1'b0;
        flush_id_ex_o    = 1'b0;
        busy_o           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d       = REDIR;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            REDIR: begin
                redirect_valid_o = 1'b1;
                flush_if_id_o    = 1'b1;
                busy_o           = 1'b1;
                if (fetch_ready_i) begin
                    if (FETCH_LAT > 0) begin
                        state_d  = SETTLE;
                        settle_d = 3'(FETCH_LAT);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SETTLE: begin
                flush_if_id_o = 1'b1;
                busy_o        = 1'b1;
                if (settle_q <= 3'd1) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                settle_d = '0;
            end
        endcase
        // Flushes must not fire while the core is being reset.
        flush_if_id_o = flush_if_id_o & rst_ni;
        flush_id_ex_o = flush_id_ex_o & rst_ni;
    end

    // Redirect target capture and misalignment pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            redirect_pc_o <= '0;
            misalign_o    <= 1'b0;
        end else begin
            if (take) begin
                redirect_pc_o <= ex_target_i;
            end
            misalign_o <= take_misaligned;
        end
    end

    // Saturating branch statistics.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bj_count_o    <= '0;
            taken_count_o <= '0;
        end else begin
            if (resolve && (bj_count_o != '1)) begin
                bj_count_o <= bj_count_o + 1'b1;
            end
            if ((take || take_misaligned) && (taken_count_o != '1)) begin
                taken_count_o <= taken_count_o + 1'b1;
            end
        end
    end

endmodule
